fifo_rd_stream: RTL and testbench

Read-side drain controller for the team's async FIFO; sits entirely in the read clock domain. Issues `r_en` against the FIFO's `empty` flag, absorbs the FIFO's one-cycle registered read latency, and presents words on a valid/ready stream through a 2-entry output buffer. Sustains one word per cycle under continuous `m_ready` and never reads an empty FIFO.

---
 rtl/fifo_rd_stream.sv | 93 +++++++++
 tb/tb_fifo_rd_stream.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Purpose : read-side drain for the async FIFO; issues r_en against empty and streams words out valid/ready.
// Latency : r_en in cycle N -> data_out in N+1 -> m_valid in N+2; one word per cycle when streaming.
// Backpressure: with m_ready low at most two words are fetched (buffer full), then r_en holds low until a pop.
//
// Ports:
//   r_clk, rrst_n    read-domain clock, synchronous active-low reset
//   empty, data_out  FIFO status and read data (data_out valid one cycle after r_en)
//   r_en             FIFO read strobe (combinational)
//   flush            drops all buffered and in-flight words
//   m_valid/m_ready/m_data  output stream
//   rd_count         accepted-word counter, present only when FIFO_RD_CNT_EN is defined
module fifo_rd_stream #(
  parameter int data_width = 8,
  parameter int cnt_width  = 16
) (
  input  logic                  r_clk,
  input  logic                  rrst_n,
  input  logic                  empty,
  input  logic [data_width-1:0] data_out,
  output logic                  r_en,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [data_width-1:0] m_data
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [cnt_width-1:0]  rd_count
`endif
);

  logic [1:0]            count_q;
  logic                  inflight_q;
  logic                  head_q;
  logic [data_width-1:0] buf_q [2];

  logic       pop;
  logic       push;
  logic       tail;
  logic [2:0] level;

  assign m_valid = (count_q != 2'd0);
  assign m_data  = buf_q[head_q];

  // A flush cycle accepts nothing downstream.
  assign pop  = m_valid && m_ready && !flush;
  assign push = inflight_q && !flush;
  assign tail = head_q ^ count_q[0];

  // Occupancy the buffer will have once the in-flight word lands and any pop
  // retires; a new read is allowed only if that leaves a slot for it.
  assign level = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign r_en  = rrst_n && !empty && !flush && (level <= 3'd1);

  always_ff @(posedge r_clk) begin
    if (!rrst_n) begin
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else if (flush) begin
      // The word on data_out this cycle is simply not captured.
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= 1'b0;
    end else begin
      inflight_q <= r_en;
      if (push) begin
        buf_q[tail] <= data_out;
      end
      if (pop) begin
        head_q <= ~head_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

`ifdef FIFO_RD_CNT_EN
  logic [cnt_width-1:0] rd_count_q;

  // Counts accepted words; survives flush, wraps naturally.
  always_ff @(posedge r_clk) begin
    if (!rrst_n) begin
      rd_count_q <= '0;
    end else if (pop) begin
      rd_count_q <= rd_count_q + 1'b1;
    end
  end

  assign rd_count = rd_count_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

  logic       r_clk = 1'b0;
  logic       rrst_n;
  logic       empty;
  logic [7:0] data_out;
  logic       r_en;
  logic       flush;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
`ifdef FIFO_RD_CNT_EN
  logic [15:0] rd_count;
`endif

  fifo_rd_stream #(.data_width(8), .cnt_width(16)) dut (
    .r_clk    (r_clk),
    .rrst_n   (rrst_n),
    .empty    (empty),
    .data_out (data_out),
    .r_en     (r_en),
    .flush    (flush),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data)
`ifdef FIFO_RD_CNT_EN
    ,
    .rd_count (rd_count)
`endif
  );

  always #5 r_clk = ~r_clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] fq[$];       // FIFO contents model
  logic [7:0] got[$];      // words popped from the stream
  int         pop_cyc[$];  // cycle number of each pop
  int         cyc = 0;
  int         ren_pulses = 0;
  int         guard_viol = 0;
  logic       last_ren = 1'b0;
  logic       toggle_mode = 1'b0;
  logic       empty_mask = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic upd_empty();
    empty = (fq.size() == 0) || (toggle_mode && empty_mask);
  endtask

  task automatic push_word(input logic [7:0] w);
    fq.push_back(w);
    upd_empty();
  endtask

  // One clock cycle: observe combinational outputs for the current cycle,
  // model the FIFO's registered read at the edge, return at the next negedge.
  task automatic step();
    logic ren;
    #1;
    ren = r_en;
    last_ren = ren;
    if (ren && empty) guard_viol++;
    if (rrst_n && m_valid && m_ready && !flush) begin
      got.push_back(m_data);
      pop_cyc.push_back(cyc);
    end
    @(posedge r_clk);
    #1;
    cyc++;
    if (ren) begin
      ren_pulses++;
      if (fq.size() > 0) data_out = fq.pop_front();
    end
    if (toggle_mode) empty_mask = ~empty_mask;
    upd_empty();
    @(negedge r_clk);
  endtask

  task automatic run_until(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (got.size() < n && k < budget) begin
      step();
      k++;
    end
    chk(tag, got.size(), n);
  endtask

  initial begin
    int base;
    int rc_before;
    logic stable;
    rrst_n   = 1'b0;
    flush    = 1'b0;
    m_ready  = 1'b1;
    data_out = 8'h00;
    fq.push_back(8'hAB);
    upd_empty();
    @(negedge r_clk);

    // Reset held 3 cycles with a non-empty FIFO.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_ren",   {31'd0, last_ren}, 32'd0);
      chk("rst_valid", {31'd0, m_valid},  32'd0);
      chk("rst_data",  {24'd0, m_data},   32'h00);
    end
`ifdef FIFO_RD_CNT_EN
    chk("rst_count", {16'd0, rd_count}, 32'd0);
`endif
    rrst_n = 1'b1;

    // Single word 0xAB then 0xCD.
    for (int w = 0; w < 2; w++) begin
      if (w == 1) push_word(8'hCD);
      step();
      chk("single_ren_n",    {31'd0, last_ren}, 32'd1);
      chk("single_valid_n1", {31'd0, m_valid},  32'd0);
      step();
      chk("single_ren_n1",   {31'd0, last_ren}, 32'd0);
      chk("single_valid_n2", {31'd0, m_valid},  32'd1);
      chk("single_data",     {24'd0, m_data},   (w == 0) ? 32'hAB : 32'hCD);
      step();
      chk("single_one_wide", {31'd0, m_valid},  32'd0);
    end
    chk("single_order0", {24'd0, got[0]}, 32'hAB);
    chk("single_order1", {24'd0, got[1]}, 32'hCD);

    // Streaming 16 words.
    base = got.size();
    for (int i = 0; i < 16; i++) push_word(i[7:0]);
    run_until(base + 16, 40, "stream_count");
    for (int i = 0; i < 16; i++) chk("stream_order", {24'd0, got[base + i]}, i);
    chk("stream_no_bubble", pop_cyc[base + 15] - pop_cyc[base], 32'd15);
`ifdef FIFO_RD_CNT_EN
    chk("stream_rd_count", {16'd0, rd_count}, 32'd18);
`endif

    // Backpressure: 4 words, m_ready low for 10 cycles.
    base = got.size();
    m_ready = 1'b0;
    ren_pulses = 0;
    for (int i = 0; i < 4; i++) push_word(8'h20 + i[7:0]);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i >= 2 && (!m_valid || m_data !== 8'h20)) stable = 1'b0;
    end
    chk("bp_ren_pulses", ren_pulses, 32'd2);
    chk("bp_data_stable", {31'd0, stable}, 32'd1);
    m_ready = 1'b1;
    run_until(base + 4, 20, "bp_count");
    for (int i = 0; i < 4; i++) chk("bp_order", {24'd0, got[base + i]}, 32'h20 + i);
    for (int i = 0; i < 4; i++) step();
    chk("bp_no_dup", got.size(), base + 4);

    // Empty flag toggling every cycle.
    base = got.size();
    toggle_mode = 1'b1;
    for (int i = 0; i < 6; i++) push_word(8'h40 + i[7:0]);
    run_until(base + 6, 60, "guard_count");
    toggle_mode = 1'b0;
    upd_empty();
    for (int i = 0; i < 6; i++) chk("guard_order", {24'd0, got[base + i]}, 32'h40 + i);
    chk("guard_no_empty_read", guard_viol, 32'd0);

    // Flush with one word buffered and one in flight.
    for (int i = 0; i < 4; i++) step();
    base = got.size();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'h50 + i[7:0]);
    step();
    step();
    chk("fl_valid_c", {31'd0, m_valid}, 32'd1);
    chk("fl_data_c",  {24'd0, m_data},  32'h50);
    m_ready = 1'b1;
    step();
    chk("fl_data_d",  {24'd0, m_data},  32'h51);
    flush = 1'b1;
`ifdef FIFO_RD_CNT_EN
    rc_before = int'(rd_count);
`else
    rc_before = 0;
`endif
    step();
    chk("fl_ren_during", {31'd0, last_ren}, 32'd0);
    chk("fl_valid_after", {31'd0, m_valid}, 32'd0);
    flush = 1'b0;
`ifdef FIFO_RD_CNT_EN
    chk("fl_rd_count_hold", {16'd0, rd_count}, rc_before);
`endif
    run_until(base + 2, 20, "fl_count");
    chk("fl_first",     {24'd0, got[base]},     32'h50);
    chk("fl_next_word", {24'd0, got[base + 1]}, 32'h53);
    chk("fl_fifo_drained", fq.size(), 32'd0);
`ifdef FIFO_RD_CNT_EN
    chk("fl_rd_count_end", {16'd0, rd_count}, 32'd30);
`endif
    chk("total_guard", guard_viol, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
